// File: rtl/led_shift_ctrl.sv
// Serial LED driver sequencer: shifts a parallel pattern out LSB-first on a divided
// shift clock, pulses the latch, and drives output-enable with a PWM brightness signal.
module led_shift_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CLKDIV   = 2,
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [PWM_BITS-1:0] bright,
    input  logic                blank,
    output logic                sclk,
    output logic                sdo,
    output logic                ltch,
    output logic                oe,
    output logic                done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(CLKDIV + 1);
    localparam logic [BW-1:0] BITS_INIT = BW'(WIDTH);
    localparam logic [DW-1:0] DIV_INIT  = DW'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_shift;
    logic [BW-1:0]       r_bits;
    logic [DW-1:0]       r_div;
    logic                r_sclk;
    logic                r_sdo;
    logic                r_ltch;
    logic                r_done;
    logic                r_oe;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright_q;

    logic [WIDTH-1:0]    w_shift_next;
    logic [PWM_BITS-1:0] w_bright_eff;
    logic                w_ready;

    assign w_ready      = (r_state == S_IDLE);
    assign w_shift_next = r_shift >> 1;

    // The sclk register doubles as the phase flag: low phase while 0, high phase while 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_ltch  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_valid && w_ready) begin
                        r_shift <= wr_data;
                        r_sdo   <= wr_data[0];
                        r_bits  <= BITS_INIT;
                        r_div   <= DIV_INIT;
                        r_sclk  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_div != '0) begin
                        r_div <= r_div - 1'b1;
                    end else begin
                        r_div <= DIV_INIT;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // sdo only moves here, at the start of a low phase.
                            r_sclk  <= 1'b0;
                            r_shift <= w_shift_next;
                            r_sdo   <= w_shift_next[0];
                            r_bits  <= r_bits - 1'b1;
                            if (r_bits == BW'(1)) begin
                                r_state <= S_LATCH;
                                r_ltch  <= 1'b1;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (r_div != '0) begin
                        r_div <= r_div - 1'b1;
                    end else begin
                        r_ltch  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // At the wrap cycle the freshly sampled brightness is used so every period is uniform.
    assign w_bright_eff = (r_pwm_cnt == '0) ? bright : r_bright_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm_cnt  <= '0;
            r_bright_q <= '0;
            r_oe       <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == '0) begin
                r_bright_q <= bright;
            end
            r_oe <= !blank && (r_pwm_cnt < w_bright_eff);
        end
    end

    assign wr_ready = w_ready;
    assign sclk     = r_sclk;
    assign sdo      = r_sdo;
    assign ltch     = r_ltch;
    assign oe       = r_oe;
    assign done     = r_done;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl with a behavioural led_driver model on each instance;
// expected latencies are hand-computed for CLKDIV=2 (main) and CLKDIV=1 (second instance).
module tb_led_shift_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       wrValid, wrValid1;
    logic [7:0] wrData, wrData1;
    logic [3:0] bright;
    logic       blank;
    logic       wrReady, sclk, sdo, ltch, oe, done;
    logic       wrReady1, sclk1, sdo1, ltch1, oe1, done1;

    int checks = 0;
    int errors = 0;

    logic [7:0] drvSr = '0, drvOut = '0, drv1Sr = '0, drv1Out = '0;
    int sclkRises = 0, ltchRises = 0, sclk1Rises = 0, ltch1Rises = 0;

    always #5 clock = ~clock;

    led_shift_ctrl #(.WIDTH(8), .CLKDIV(2), .PWM_BITS(4)) dut (
        .clock(clock), .reset(reset), .wr_valid(wrValid), .wr_ready(wrReady),
        .wr_data(wrData), .bright(bright), .blank(blank), .sclk(sclk), .sdo(sdo),
        .ltch(ltch), .oe(oe), .done(done)
    );

    led_shift_ctrl #(.WIDTH(8), .CLKDIV(1), .PWM_BITS(4)) dut1 (
        .clock(clock), .reset(reset), .wr_valid(wrValid1), .wr_ready(wrReady1),
        .wr_data(wrData1), .bright(bright), .blank(blank), .sclk(sclk1), .sdo(sdo1),
        .ltch(ltch1), .oe(oe1), .done(done1)
    );

    // Driver models: shift right on clock rise (si enters MSB), latch on ltch fall.
    always @(posedge sclk) begin
        drvSr <= {sdo, drvSr[7:1]};
        sclkRises++;
    end
    always @(posedge ltch) ltchRises++;
    always @(negedge ltch) drvOut <= drvSr;

    always @(posedge sclk1) begin
        drv1Sr <= {sdo1, drv1Sr[7:1]};
        sclk1Rises++;
    end
    always @(posedge ltch1) ltch1Rises++;
    always @(negedge ltch1) drv1Out <= drv1Sr;

    task automatic test_reset();
        reset = 1'b1;
        wrValid = 1'b0; wrData = '0; wrValid1 = 1'b0; wrData1 = '0;
        bright = 4'd0; blank = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({sclk, sdo, ltch, oe, done, wrReady} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected 000001", {sclk, sdo, ltch, oe, done, wrReady});
        end
        checks++;
        if ({sclk1, sdo1, ltch1, oe1, done1, wrReady1} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_outputs_div1: got %b, expected 000001", {sclk1, sdo1, ltch1, oe1, done1, wrReady1});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({sclk, ltch, done, wrReady} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b, expected 0001", {sclk, ltch, done, wrReady});
        end
    endtask

    task automatic test_transfer(input logic [7:0] data);
        int k = 0;
        int rise0, ltch0;
        bit seenDone = 0;
        bit ltchEarly = 0;
        @(negedge clock);
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_before_%h: got %b, expected 1", data, wrReady);
        end
        wrValid = 1'b1; wrData = data;
        rise0 = sclkRises; ltch0 = ltchRises;
        @(posedge clock);
        #1 wrValid = 1'b0; wrData = ~data;
        while (!seenDone && k < 100) begin
            @(negedge clock);
            k++;
            if (k < 33 && ltch !== 1'b0) ltchEarly = 1;
            if (k == 1) begin
                checks++;
                if ({sclk, sdo} !== {1'b0, data[0]}) begin
                    errors++;
                    $display("[TB] FAIL first_bit_%h: got sclk/sdo %b, expected %b", data, {sclk, sdo}, {1'b0, data[0]});
                end
            end
            if (k == 3) begin
                checks++;
                if (sclk !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL first_sclk_rise_%h: got %b, expected 1", data, sclk);
                end
            end
            if (k == 33 || k == 34) begin
                checks++;
                if (ltch !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ltch_high_%h_k%0d: got %b, expected 1", data, k, ltch);
                end
            end
            if (done === 1'b1) seenDone = 1;
        end
        checks++;
        if (k !== 35) begin
            errors++;
            $display("[TB] FAIL done_latency_%h: got %0d, expected 35", data, k);
        end
        checks++;
        if (ltchEarly) begin
            errors++;
            $display("[TB] FAIL ltch_during_shift_%h: got 1, expected 0", data);
        end
        checks++;
        if ({ltch, wrReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL done_cycle_%h: got ltch/ready %b, expected 01", data, {ltch, wrReady});
        end
        checks++;
        if (drvOut !== data) begin
            errors++;
            $display("[TB] FAIL driver_out_%h: got %h, expected %h", data, drvOut, data);
        end
        checks++;
        if (sclkRises - rise0 != 8 || ltchRises - ltch0 != 1) begin
            errors++;
            $display("[TB] FAIL edge_count_%h: got %0d rises/%0d latches, expected 8/1", data, sclkRises - rise0, ltchRises - ltch0);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int k2 = 0;
        int rise0, ltch0;
        @(negedge clock);
        wrValid = 1'b1; wrData = 8'h01;
        rise0 = sclkRises; ltch0 = ltchRises;
        @(posedge clock);
        #1 wrData = 8'h80;
        do begin
            @(negedge clock);
            k++;
        end while (done !== 1'b1 && k < 100);
        checks++;
        if (k !== 35 || wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got k=%0d ready=%b, expected k=35 ready=1", k, wrReady);
        end
        checks++;
        if (drvOut !== 8'h01) begin
            errors++;
            $display("[TB] FAIL b2b_first_out: got %h, expected 01", drvOut);
        end
        @(posedge clock);
        #1 wrValid = 1'b0;
        do begin
            @(negedge clock);
            k2++;
        end while (done !== 1'b1 && k2 < 100);
        checks++;
        if (k2 !== 35) begin
            errors++;
            $display("[TB] FAIL b2b_second_done: got %0d, expected 35", k2);
        end
        checks++;
        if (drvOut !== 8'h80) begin
            errors++;
            $display("[TB] FAIL b2b_second_out: got %h, expected 80", drvOut);
        end
        checks++;
        if (sclkRises - rise0 != 16 || ltchRises - ltch0 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_edges: got %0d rises/%0d latches, expected 16/2", sclkRises - rise0, ltchRises - ltch0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int rise0, ltch0;
        test_transfer(8'h3C);
        @(negedge clock);
        wrValid = 1'b1; wrData = 8'hFF;
        rise0 = sclkRises; ltch0 = ltchRises;
        @(posedge clock);
        #1 wrValid = 1'b0;
        while (sclkRises - rise0 < 4 && n < 200) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (sclkRises - rise0 != 4) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait: got %0d rises, expected 4", sclkRises - rise0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({sclk, sdo, ltch, oe, done, wrReady} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b, expected 000001", {sclk, sdo, ltch, oe, done, wrReady});
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (drvOut !== 8'h3C || ltchRises != ltch0) begin
            errors++;
            $display("[TB] FAIL reset_mid_hold: got out=%h latches=%0d, expected out=3C latches=%0d", drvOut, ltchRises, ltch0);
        end
        test_transfer(8'h0F);
    endtask

    task automatic test_pwm();
        int cnt = 0;
        blank = 1'b0;
        @(negedge clock);
        bright = 4'd4;
        repeat (40) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (oe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("[TB] FAIL pwm_duty_4: got %0d, expected 4", cnt);
        end
        bright = 4'd15;
        repeat (32) @(negedge clock);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (oe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 15) begin
            errors++;
            $display("[TB] FAIL pwm_duty_15: got %0d, expected 15", cnt);
        end
        bright = 4'd0;
        repeat (32) @(negedge clock);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (oe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("[TB] FAIL pwm_duty_0: got %0d, expected 0", cnt);
        end
    endtask

    task automatic test_blank();
        int n = 0;
        int cnt = 0;
        bright = 4'd15;
        repeat (40) @(negedge clock);
        while (oe !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blank_pre_oe: got %b, expected 1", oe);
        end
        blank = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL blank_latency: got %b, expected 0", oe);
        end
        test_transfer(8'hC3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (oe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("[TB] FAIL blank_hold: got %0d, expected 0", cnt);
        end
        blank = 1'b0;
        repeat (20) @(negedge clock);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (oe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 15) begin
            errors++;
            $display("[TB] FAIL unblank_duty: got %0d, expected 15", cnt);
        end
    endtask

    task automatic test_clkdiv1(input logic [7:0] data);
        int k = 0;
        int rise0;
        bit seenDone = 0;
        @(negedge clock);
        wrValid1 = 1'b1; wrData1 = data;
        rise0 = sclk1Rises;
        @(posedge clock);
        #1 wrValid1 = 1'b0; wrData1 = ~data;
        while (!seenDone && k < 100) begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                checks++;
                if ({sclk1, sdo1} !== {1'b0, data[0]}) begin
                    errors++;
                    $display("[TB] FAIL div1_first_bit_%h: got %b, expected %b", data, {sclk1, sdo1}, {1'b0, data[0]});
                end
            end
            if (k == 2 || k == 17) begin
                checks++;
                if ((k == 2 ? sclk1 : ltch1) !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL div1_phase_%h_k%0d: got sclk=%b ltch=%b, expected high", data, k, sclk1, ltch1);
                end
            end
            if (done1 === 1'b1) seenDone = 1;
        end
        checks++;
        if (k !== 18) begin
            errors++;
            $display("[TB] FAIL div1_done_latency_%h: got %0d, expected 18", data, k);
        end
        checks++;
        if (drv1Out !== data || sclk1Rises - rise0 != 8) begin
            errors++;
            $display("[TB] FAIL div1_out_%h: got %h with %0d rises, expected %h with 8", data, drv1Out, sclk1Rises - rise0, data);
        end
    endtask

    initial begin
        test_reset();
        bright = 4'd15;
        test_transfer(8'hA5);
        test_back_to_back();
        test_reset_mid();
        test_pwm();
        test_blank();
        test_clkdiv1(8'h5A);
        test_clkdiv1(8'h96);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_shift_ctrl.md
# led_shift_ctrl

Sequencer for the 8-bit serial-in LED driver. It accepts a parallel pattern over a valid/ready handshake and shifts it out LSB-first on a divided shift clock. It then pulses the latch and drives the output-enable line with a PWM brightness signal. It sits between the pattern-generating logic and the `led_driver` pins (`clock`, `si`, `ltch`, `oe`).

## Interface

Parameters:

- `WIDTH`, default 8: bits per transfer; must match the driver width (≥1).
- `CLKDIV`, default 2: system cycles per shift-clock half period (≥1).
- `PWM_BITS`, default 4: brightness resolution; PWM period is 2^PWM_BITS cycles.

Ports:

- `clock` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `wr_valid` input 1: a pattern is offered on `wr_data`.
- `wr_ready` output 1: the controller is idle and can accept a pattern.
- `wr_data` input WIDTH: the pattern; bit i ends up on driver `out[i]`.
- `bright` input PWM_BITS: duty value; 0 means off.
- `blank` input 1: forces `oe` low while high.
- `sclk` output 1: shift clock to driver `clock`.
- `sdo` output 1: serial data to driver `si`.
- `ltch` output 1: latch to driver `ltch`.
- `oe` output 1: output enable to driver `oe`.
- `done` output 1: one-cycle pulse when a transfer completes.

## Operation

- States: IDLE, SHIFT, LATCH.
- IDLE:
  - `wr_ready`=1.
  - On `wr_valid`&`wr_ready`, capture `wr_data` into the shift register, load the bit counter with WIDTH and the divider counter with CLKDIV-1, and go to SHIFT.
- SHIFT:
  - Each bit has a low phase of CLKDIV cycles (`sclk`=0) then a high phase of CLKDIV cycles (`sclk`=1).
  - `sdo` = shift register bit 0. It is updated only at the start of a low phase, so it is stable across the rising edge of `sclk`.
  - At the end of each high phase, shift the register right and decrement the bit counter.
  - After WIDTH bits, go to LATCH.
  - `ltch`=0 throughout, because the driver shifts only while `ltch` is low.
- LATCH:
  - `sclk`=0 and `ltch`=1 for CLKDIV cycles.
  - Then go to IDLE with `ltch`=0 and assert `done` for 1 cycle.
- Bit order: LSB first. The first bit shifted lands in driver bit 0 after WIDTH shifts.
- PWM:
  - The free-running counter `pwm_cnt` (PWM_BITS wide) wraps 2^PWM_BITS-1 → 0.
  - `bright` is sampled into `bright_q` only when `pwm_cnt`==0, so there is no mid-period glitch.
  - `oe` = !`blank` && (`pwm_cnt` < `bright_q`).
  - Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- PWM runs independently of the shift FSM. The driver holds its latched value during shifting, so there is no blanking during transfers.
- `wr_data` changes while not accepted are ignored. `wr_valid` in SHIFT or LATCH is held off by `wr_ready`=0.
- All outputs are registered except `wr_ready`, which is decoded from state.

## Timing

- Reset values:
  - state IDLE
  - `sclk`=0, `sdo`=0, `ltch`=0, `oe`=0, `done`=0
  - `wr_ready`=1
  - `pwm_cnt`=0, `bright_q`=0
- Handshake:
  - Acceptance occurs in cycle T.
  - First `sdo` bit is valid at T+1.
  - First `sclk` rise is at T+1+CLKDIV.
- Bit k (0-based) timing:
  - `sdo` = `wr_data[k]` from T+1+2k·CLKDIV.
  - `sclk` rises at T+1+(2k+1)·CLKDIV.
- Latch and completion:
  - `ltch` is high during cycles T+1+2·WIDTH·CLKDIV through T+2·WIDTH·CLKDIV+CLKDIV.
  - `done`=1 and `wr_ready`=1 at T+1+(2·WIDTH+1)·CLKDIV. With defaults this is T+35.
- Back-to-back: a new `wr_valid` is accepted in the `done` cycle. There are no dead cycles beyond that.
- Reset mid-transfer:
  - All outputs return to reset values immediately, and no latch pulse is produced.
  - The driver keeps its previously latched pattern.
  - The partially shifted driver register is fully overwritten by the next transfer.
- `blank` affects `oe` with 1-cycle latency because `oe` is registered.
- A `bright` change takes effect at the next `pwm_cnt` wrap, 1–2^PWM_BITS cycles later.

## Test plan

- After reset (defaults), offer `wr_valid` with `wr_data`=8'hA5 → with `led_driver` attached, driver `out`=8'hA5 once `ltch` falls and `oe` is high. `done` pulses at T+35, and exactly 8 `sclk` rises and 1 `ltch` pulse occur.
- Back-to-back 8'h01 then 8'h80 with `wr_valid` held → the second is accepted in the `done` cycle of the first. The driver shows 01 then 80, with no extra `sclk` edges.
- Assert `reset` at the 4th `sclk` rise during a transfer of 8'hFF after 8'h3C was latched → all outputs go to 0 immediately and the driver still latches 3C. The next transfer of 8'h0F latches 0F.
- `bright`=4 with PWM_BITS=4 → `oe` is high 4 of every 16 cycles. Changing to 15 mid-period → the new duty of 15/16 starts after the next wrap. `bright`=0 → `oe` stays 0.
- `blank`=1 with `bright`=15 → `oe`=0 starting 1 cycle after `blank` rises. Shifting and latching are unaffected.
- CLKDIV=1, WIDTH=8 → `sclk` period is 2 cycles, the `done` pulse is at T+18, and `sdo` is stable at every `sclk` rise.
